// File: rtl/mac_pkg.sv
// Shared types, default sizes and helpers for the MAC sequencer slice.
package mac_pkg;

    // Controller states: waiting for a job, streaming beats, holding a result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int BW      = 4;
    localparam int PSUM_BW = 16;
    localparam int LEN_BW  = 8;

    // Two's-complement add overflows when both operands share a sign and the
    // result does not.
    function automatic logic add_ovf(input logic a_neg, input logic b_neg, input logic sum_neg);
        return (a_neg == b_neg) && (sum_neg != a_neg);
    endfunction

endpackage

// File: rtl/mac_seq_ctrl_if.sv
// Operand stream (activation/weight) and result stream of the MAC sequencer.
// slave is the controller side, master is the buffer/writeback side.
interface mac_seq_ctrl_if #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
);
    logic        [bw-1:0]      a_data;
    logic signed [bw-1:0]      b_data;
    logic                      ab_valid;
    logic                      ab_ready;
    logic signed [psum_bw-1:0] out_psum;
    logic                      out_ovf;
    logic                      out_valid;
    logic                      out_ready;

    modport master (
        output a_data, b_data, ab_valid, out_ready,
        input  ab_ready, out_psum, out_ovf, out_valid
    );

    modport slave (
        input  a_data, b_data, ab_valid, out_ready,
        output ab_ready, out_psum, out_ovf, out_valid
    );
endinterface

// File: rtl/mac_cell.sv
// Combinational MAC: psum = zext(a) * sext(b) + acc_in, wrapping at psum_bw.
module mac_cell #(
    parameter int bw      = 4,
    parameter int psum_bw = 16
) (
    input  logic        [bw-1:0]      a,
    input  logic signed [bw-1:0]      b,
    input  logic signed [psum_bw-1:0] acc_in,
    output logic signed [psum_bw-1:0] psum
);

    logic signed [2*bw:0]      prod;
    logic signed [psum_bw-1:0] prod_ext;

    // Product of an unsigned activation and a signed weight, sign-extended to the accumulator.
    always_comb begin
        prod     = $signed({1'b0, a}) * b;
        prod_ext = psum_bw'(prod);
        psum     = acc_in + prod_ext;
    end

endmodule

// File: rtl/mac_seq_ctrl.sv
// Sequencer around one MAC cell: accumulates a K-term dot product from a
// valid/ready operand stream and hands the result over a valid/ready output.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int bw      = BW,
    parameter int psum_bw = PSUM_BW,
    parameter int len_bw  = LEN_BW
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [len_bw-1:0] len,
    output logic              busy,
    mac_seq_ctrl_if.slave     bus
);

    if (psum_bw < 2*bw + 1) begin : g_bad_psum_bw
        $error("mac_seq_ctrl: psum_bw must be at least 2*bw+1");
    end

    state_e                    state_q, state_d;
    logic signed [psum_bw-1:0] acc_q, acc_d;
    logic        [len_bw-1:0]  cnt_q, cnt_d;
    logic                      ovf_q, ovf_d;
    logic signed [psum_bw-1:0] psum_q, psum_d;
    logic                      out_ovf_q, out_ovf_d;

    logic signed [psum_bw-1:0] mac_sum;
    logic                      prod_neg;
    logic                      beat_ovf;

    mac_cell #(
        .bw      (bw),
        .psum_bw (psum_bw)
    ) u_mac (
        .a      (bus.a_data),
        .b      (bus.b_data),
        .acc_in (acc_q),
        .psum   (mac_sum)
    );

    // Overflow of this beat's add; a zero product is non-negative whatever the weight sign.
    always_comb begin
        prod_neg = bus.b_data[bw-1] && (bus.a_data != '0);
        beat_ovf = add_ovf(acc_q[psum_bw-1], prod_neg, mac_sum[psum_bw-1]);
    end

    // Handshake outputs are decoded from registered state only, so neither
    // ab_valid nor out_ready reaches any output combinationally.
    assign bus.ab_ready  = (state_q == RUN);
    assign bus.out_valid = (state_q == DONE);
    assign busy          = (state_q != IDLE);
    assign bus.out_psum  = psum_q;
    assign bus.out_ovf   = out_ovf_q;

    // Next-state, accumulation and result capture.
    always_comb begin
        // NOTE: every variable gets its hold value first, so no path through the case can infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        ovf_d     = ovf_q;
        psum_d    = psum_q;
        out_ovf_d = out_ovf_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d = '0;
                    ovf_d = 1'b0;
                    cnt_d = len;
                    if (len == '0) begin
                        state_d   = DONE;
                        psum_d    = '0;
                        out_ovf_d = 1'b0;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (bus.ab_valid) begin
                    acc_d = mac_sum;
                    ovf_d = ovf_q | beat_ovf;
                    cnt_d = cnt_q - len_bw'(1);
                    if (cnt_q == len_bw'(1)) begin
                        state_d   = DONE;
                        psum_d    = mac_sum;
                        out_ovf_d = ovf_q | beat_ovf;
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset abandons any job in flight and clears the result.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            cnt_q     <= '0;
            ovf_q     <= 1'b0;
            psum_q    <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values regardless of statement order.
            state_q   <= state_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            ovf_q     <= ovf_d;
            psum_q    <= psum_d;
            out_ovf_q <= out_ovf_d;
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Self-checking bench for mac_seq_ctrl: directed table, multi-cycle corner
// sequences and random jobs against an arithmetic dot-product model.
module tb_mac_seq_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start, start9;
    logic [7:0] len, len9;
    logic       busy, busy9;

    always #5 clk = ~clk;

    mac_seq_ctrl_if #(.bw(4), .psum_bw(16)) bus16 ();
    mac_seq_ctrl_if #(.bw(4), .psum_bw(9))  bus9 ();

    mac_seq_ctrl u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .len     (len),
        .busy    (busy),
        .bus     (bus16)
    );

    mac_seq_ctrl #(.psum_bw(9)) u_dut9 (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start9),
        .len     (len9),
        .busy    (busy9),
        .bus     (bus9)
    );

    int total = 0;
    int bad   = 0;

    logic [3:0] aq[$];
    logic [3:0] bq[$];

    typedef struct {
        int          len;
        logic [15:0] a_vec;   // beat i in bits [4*i +: 4]
        logic [15:0] b_vec;
        int          gap;
        int          exp_psum;
        bit          exp_ovf;
    } vec_t;

    vec_t tbl[6];

    task automatic check(input string name, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Reference: exact integer dot product, wrapped to p bits, with overflow
    // whenever an exact running sum leaves the signed p-bit range.
    task automatic model_dot(input int n, input int p, output int psum, output bit ovf);
        int acc, t, lo, hi, m, prod;
        lo  = -(1 << (p - 1));
        hi  = (1 << (p - 1)) - 1;
        m   = 1 << p;
        acc = 0;
        ovf = 1'b0;
        for (int i = 0; i < n; i++) begin
            prod = int'(aq[i]) * int'($signed(bq[i]));
            t    = acc + prod;
            if (t > hi || t < lo) ovf = 1'b1;
            acc = (((t - lo) % m) + m) % m + lo;
        end
        psum = acc;
    endtask

    // One job on the 16-bit DUT from aq/bq; gap<0 means random bubbles.
    task automatic run_job(input int n, input int gap, input int rdy_delay,
                           output logic signed [31:0] got_psum, output logic got_ovf);
        int g, w;
        start = 1'b1;
        len   = n[7:0];
        @(negedge clk);
        start = 1'b0;
        check("busy_after_start", busy, 1);
        for (int i = 0; i < n; i++) begin
            bus16.a_data   = aq[i];
            bus16.b_data   = bq[i];
            bus16.ab_valid = 1'b1;
            w = 0;
            while (!bus16.ab_ready && w < 20) begin
                @(negedge clk);
                w++;
            end
            if (!bus16.ab_ready) begin
                check("ab_ready_timeout", bus16.ab_ready, 1);
                break;
            end
            @(negedge clk);
            bus16.ab_valid = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
            if (i < n - 1) repeat (g) @(negedge clk);
        end
        bus16.ab_valid = 1'b0;
        check("out_valid_latency", bus16.out_valid, 1);
        check("ab_ready_in_done", bus16.ab_ready, 0);
        w = 0;
        while (!bus16.out_valid && w < 50) begin
            @(negedge clk);
            w++;
        end
        repeat (rdy_delay) @(negedge clk);
        bus16.out_ready = 1'b1;
        got_psum = $signed(bus16.out_psum);
        got_ovf  = bus16.out_ovf;
        @(negedge clk);
        bus16.out_ready = 1'b0;
        check("busy_after_handshake", busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic signed [31:0] got_psum;
        logic               got_ovf;
        int                 exp_psum;
        bit                 exp_ovf;
        int                 n;

        tbl[0] = '{4, 16'h4321, 16'h1111, 0,    10, 1'b0};
        tbl[1] = '{3, 16'h0FFF, 16'h0888, 2,  -360, 1'b0};
        tbl[2] = '{0, 16'h0000, 16'h0000, 0,     0, 1'b0};
        tbl[3] = '{2, 16'h00FF, 16'h0077, 1,   210, 1'b0};
        tbl[4] = '{1, 16'h0000, 16'h0008, 0,     0, 1'b0};
        tbl[5] = '{4, 16'h321F, 16'hD7EF, 1,   -12, 1'b0};

        reset_n         = 1'b0;
        start           = 1'b0;
        len             = '0;
        start9          = 1'b0;
        len9            = '0;
        bus16.a_data    = '0;
        bus16.b_data    = '0;
        bus16.ab_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        bus9.a_data     = '0;
        bus9.b_data     = '0;
        bus9.ab_valid   = 1'b0;
        bus9.out_ready  = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_ab_ready", bus16.ab_ready, 0);
        check("rst_out_valid", bus16.out_valid, 0);
        check("rst_out_psum", $signed(bus16.out_psum), 0);
        check("rst_out_ovf", bus16.out_ovf, 0);
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_busy", busy, 0);

        // Directed table
        for (int r = 0; r < 6; r++) begin
            aq.delete();
            bq.delete();
            for (int i = 0; i < tbl[r].len; i++) begin
                aq.push_back(tbl[r].a_vec[4*i +: 4]);
                bq.push_back(tbl[r].b_vec[4*i +: 4]);
            end
            run_job(tbl[r].len, tbl[r].gap, r % 3, got_psum, got_ovf);
            check($sformatf("tbl%0d_psum", r), got_psum, tbl[r].exp_psum);
            check($sformatf("tbl%0d_ovf", r), got_ovf, tbl[r].exp_ovf);
        end

        // Result back-pressure: start and ab_valid must be ignored in DONE
        start = 1'b1;
        len   = 8'd1;
        @(negedge clk);
        start          = 1'b0;
        bus16.a_data   = 4'd5;
        bus16.b_data   = 4'd3;
        bus16.ab_valid = 1'b1;
        @(negedge clk);
        start          = 1'b1;
        len            = 8'd3;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_out_valid", bus16.out_valid, 1);
            check("bp_out_psum", $signed(bus16.out_psum), 15);
            check("bp_ab_ready", bus16.ab_ready, 0);
        end
        bus16.out_ready = 1'b1;
        @(negedge clk);
        check("bp_released_valid", bus16.out_valid, 0);
        check("bp_released_busy", busy, 0);
        start           = 1'b0;
        bus16.ab_valid  = 1'b0;
        bus16.out_ready = 1'b0;
        @(negedge clk);
        check("bp_idle_busy", busy, 0);
        check("bp_psum_held", $signed(bus16.out_psum), 15);

        // Reset in the middle of a job
        start = 1'b1;
        len   = 8'd4;
        @(negedge clk);
        start          = 1'b0;
        bus16.a_data   = 4'd7;
        bus16.b_data   = 4'd7;
        bus16.ab_valid = 1'b1;
        repeat (2) @(negedge clk);
        bus16.ab_valid = 1'b0;
        reset_n        = 1'b0;
        #1;
        check("midrst_busy", busy, 0);
        check("midrst_ab_ready", bus16.ab_ready, 0);
        check("midrst_out_valid", bus16.out_valid, 0);
        check("midrst_out_psum", $signed(bus16.out_psum), 0);
        check("midrst_out_ovf", bus16.out_ovf, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        aq = '{4'd2, 4'd3};
        bq = '{4'hF, 4'd2};
        run_job(2, 0, 0, got_psum, got_ovf);
        check("after_rst_psum", got_psum, 4);
        check("after_rst_ovf", got_ovf, 0);

        // Narrow accumulator (psum_bw=9): wrap and sticky overflow, then a clean job
        aq = '{4'd15, 4'd15, 4'd15};
        bq = '{4'd7, 4'd7, 4'd7};
        model_dot(3, 9, exp_psum, exp_ovf);
        start9 = 1'b1;
        len9   = 8'd3;
        @(negedge clk);
        start9 = 1'b0;
        check("n9_ab_ready", bus9.ab_ready, 1);
        for (int i = 0; i < 3; i++) begin
            bus9.a_data   = aq[i];
            bus9.b_data   = bq[i];
            bus9.ab_valid = 1'b1;
            @(negedge clk);
        end
        bus9.ab_valid = 1'b0;
        check("n9_out_valid", bus9.out_valid, 1);
        check("n9_psum", $signed(bus9.out_psum), -197);
        check("n9_ovf", bus9.out_ovf, 1);
        check("n9_psum_model", $signed(bus9.out_psum), exp_psum);
        check("n9_ovf_model", bus9.out_ovf, exp_ovf);
        bus9.out_ready = 1'b1;
        @(negedge clk);
        bus9.out_ready = 1'b0;
        start9 = 1'b1;
        len9   = 8'd1;
        @(negedge clk);
        start9        = 1'b0;
        bus9.a_data   = 4'd1;
        bus9.b_data   = 4'd1;
        bus9.ab_valid = 1'b1;
        @(negedge clk);
        bus9.ab_valid = 1'b0;
        check("n9b_out_valid", bus9.out_valid, 1);
        check("n9b_psum", $signed(bus9.out_psum), 1);
        check("n9b_ovf", bus9.out_ovf, 0);
        bus9.out_ready = 1'b1;
        @(negedge clk);
        bus9.out_ready = 1'b0;
        check("n9b_busy", busy9, 0);

        // Random jobs against the model
        for (int j = 0; j < 25; j++) begin
            n = int'($urandom_range(1, 8));
            aq.delete();
            bq.delete();
            for (int i = 0; i < n; i++) begin
                aq.push_back(4'($urandom));
                bq.push_back(4'($urandom));
            end
            model_dot(n, 16, exp_psum, exp_ovf);
            run_job(n, -1, int'($urandom_range(0, 3)), got_psum, got_ovf);
            check($sformatf("rnd%0d_psum", j), got_psum, exp_psum);
            check($sformatf("rnd%0d_ovf", j), got_ovf, exp_ovf);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
